bus_frame_receiver: RTL and testbench
=====================================

// Module: bus_frame_receiver
// PURPOSE
//  Receiving end of the arbitrated byte bus. Reassembles the LSB-first byte stream driven by the
//  AES/SHA bus arbiter into full {addr, op} words, tags each word with its source FSM, and
//  buffers words in a small FIFO. Drains through a valid/ready port to the memory/control side.
//  The bus has no backpressure: this block must absorb or flag every frame.
// PARAMETERS
//  ADDRW       24  address width; ADDRW % 8 == 0; word width W = ADDRW+8, NB = W/8 bytes per frame
//  FIFO_DEPTH  2   word FIFO entries; power of 2, >= 2
//  TIMEOUT     15  idle cycles allowed between bytes of one frame (only with TIMEOUT feature)
// PORTS
//  clk        in   1  clock, all state on posedge
//  rst_n      in   1  asynchronous active-low reset
//  bus_valid  in   1  byte strobe; one byte per cycle when high
//  bus_data   in   8  byte; frame byte 0 = word[7:0], byte NB-1 = word[W-1:W-8]
//  bus_src    in   2  owner of the byte: 01 AES, 10 SHA; 00/11 illegal
//  out_valid  out  1  FIFO head valid
//  out_ready  in   1  consumer accepts head when out_valid && out_ready
//  out_data   out  W  head word; op = out_data[7:0], addr = out_data[W-1:8]
//  out_src    out  2  head word source tag (01 AES, 10 SHA)
//  busy       out  1  partial frame held (byte count != 0)
//  frame_err  out  1  one-cycle pulse: partial frame discarded or illegal byte
//  overflow   out  1  one-cycle pulse: completed word dropped, FIFO full
// BEHAVIOUR
//  Reset: FSM IDLE, byte count 0, FIFO empty; out_valid=0, out_data=0, out_src=00, busy=0,
//   frame_err=0, overflow=0. Reset mid-frame or with FIFO non-empty discards everything.
//  FSM IDLE: bus_valid with legal src -> shift byte into assembly reg slot 0, latch src, cnt=1,
//   go COLLECT. Illegal src -> byte ignored, frame_err pulse, stay IDLE.
//  FSM COLLECT: bus_valid, src == latched src -> store byte at slot cnt, cnt++.
//   On byte NB-1: push {word, src} to FIFO, cnt=0, go IDLE (next byte may arrive next cycle).
//  Source change mid-frame (legal new src): frame_err pulse, partial dropped, new byte taken
//   as byte 0 of a new frame under new src (stay COLLECT, cnt=1).
//  Illegal src in COLLECT: frame_err pulse, partial dropped, go IDLE.
//  bus_valid low in COLLECT: hold state (no error unless TIMEOUT feature fires).
//  Latency: last byte sampled at edge N -> out_valid=1 after edge N (visible cycle N+1) if FIFO
//   was empty. Back-to-back frames sustain 1 word per NB cycles.
//  FIFO: registered storage, pointers log2(FIFO_DEPTH)+1 bits, wrap naturally. out_data/out_src
//   show head; hold stable while out_valid && !out_ready. Pop on out_valid && out_ready.
//  Full + push + pop same cycle: both succeed, no overflow. Full + push, no pop: word dropped,
//   overflow pulse, FIFO contents unchanged. Empty: out_data/out_src hold last value.
//  frame_err and overflow may pulse in the same cycle; both are independent.
// CONFIGURATION
//  BUS_RX_TIMEOUT_EN defined: in COLLECT a counter clears on every accepted byte and counts
//   idle cycles; reaching TIMEOUT -> partial dropped, frame_err pulse, go IDLE, cnt=0.
//   Counter is held at 0 in IDLE.
//  Not defined: no timeout counter; a partial frame waits indefinitely; TIMEOUT unused.
// TESTING
//  T1 bytes 0xEF,0xBE,0xAD,0xDE src=01 consecutive, out_ready=1 -> one cycle after last byte
//     out_valid=1, out_data=0xDEADBEEF, out_src=01; busy 1 for bytes 1-3 only.
//  T2 SHA frame 0x11223344 then AES frame 0x55667788 back-to-back, out_ready=0 -> FIFO holds
//     both; raising out_ready pops 0x11223344/10 then 0x55667788/01, then out_valid=0.
//  T3 out_ready=0, three frames (depth 2) -> overflow pulses exactly once at 3rd frame's last
//     byte; drained words are frames 1 and 2 only.
//  T4 two AES bytes then SHA byte 0xAA -> frame_err pulse; following 0xBB,0xCC,0xDD src=10
//     yield out_data=0xDDCCBBAA, out_src=10.
//  T5 assert rst_n=0 after 2 bytes with 1 word queued -> out_valid=0, busy=0; next full frame
//     received correctly with no error pulse.
//  T6 (BUS_RX_TIMEOUT_EN) 2 bytes then bus_valid=0 for TIMEOUT cycles -> frame_err pulse,
//     busy=0; without macro same stimulus -> busy stays 1, no pulse, frame completes later.

Source files
------------

// File: rtl/bus_frame_receiver.sv
// ---------------------------------------------------------------------------
// bus_frame_receiver
//
// Purpose:
//   Receiving end of the arbitrated byte bus. Bytes arrive LSB-first and are
//   reassembled into {addr, op} words of W = ADDRW+8 bits (NB = W/8 bytes per
//   frame). Each word is tagged with its source (01 AES, 10 SHA) and queued in
//   a small FIFO that drains through a valid/ready port. The bus cannot be
//   stalled, so every frame is either absorbed or flagged.
//
// Optional feature:
//   BUS_RX_TIMEOUT_EN - when defined, a partial frame idle for TIMEOUT cycles
//   is discarded with a frame_err pulse. When undefined, a partial frame waits
//   indefinitely and TIMEOUT is unused.
//
// Ports:
//   clk        in   clock, all state on posedge
//   rst_n      in   asynchronous active-low reset
//   bus_valid  in   byte strobe
//   bus_data   in   byte, frame byte 0 = word[7:0]
//   bus_src    in   byte owner: 01 AES, 10 SHA, 00/11 illegal
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer accepts head
//   out_data   out  head word; op = [7:0], addr = [W-1:8]
//   out_src    out  head word source tag
//   busy       out  partial frame held
//   frame_err  out  one-cycle pulse: partial frame discarded or illegal byte
//   overflow   out  one-cycle pulse: completed word dropped, FIFO full
// ---------------------------------------------------------------------------
module bus_frame_receiver #(
  parameter int ADDRW      = 24,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_valid,
  input  logic [7:0]       bus_data,
  input  logic [1:0]       bus_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADDRW+7:0] out_data,
  output logic [1:0]       out_src,
  output logic             busy,
  output logic             frame_err,
  output logic             overflow
);

  localparam int W  = ADDRW + 8;
  localparam int NB = W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  function automatic logic src_legal(input logic [1:0] s);
    return (s == 2'b01) || (s == 2'b10);
  endfunction

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [1:0]      src_r, src_nxt_s;
  logic [W-1:0]    asm_r, asm_nxt_s;
  logic            push_req_s;
  logic            err_s;

  logic [W+1:0]    mem_r [FIFO_DEPTH];
  logic [PW:0]     wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
  logic            pop_s, full_s, push_s, ovf_s;
  logic [W+1:0]    head_nxt_s;

  logic            out_valid_r;
  logic [W-1:0]    out_data_r;
  logic [1:0]      out_src_r;
  logic            busy_r;
  logic            frame_err_r;
  logic            overflow_r;

`ifdef BUS_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   tmo_r, tmo_nxt_s;
`endif

  // Frame assembly FSM: next state, byte slot writes, error and push requests.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    src_nxt_s   = src_r;
    asm_nxt_s   = asm_r;
    push_req_s  = 1'b0;
    err_s       = 1'b0;
`ifdef BUS_RX_TIMEOUT_EN
    // Idle counter is zero unless explicitly advanced below, which clears it
    // on every accepted byte and holds it at zero in IDLE.
    tmo_nxt_s   = {TW{1'b0}};
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus_valid) begin
          if (src_legal(bus_src)) begin
            asm_nxt_s[7:0] = bus_data;
            src_nxt_s      = bus_src;
            cnt_nxt_s      = CW'(1);
            state_nxt_s    = ST_COLLECT;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (bus_valid) begin
          if (!src_legal(bus_src)) begin
            err_s       = 1'b1;
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = ST_IDLE;
          end else if (bus_src != src_r) begin
            // Owner switched mid-frame: drop the partial and restart under
            // the new owner with this byte as byte 0.
            err_s          = 1'b1;
            asm_nxt_s[7:0] = bus_data;
            src_nxt_s      = bus_src;
            cnt_nxt_s      = CW'(1);
          end else begin
            asm_nxt_s[{cnt_r, 3'b000} +: 8] = bus_data;
            if (cnt_r == CW'(NB - 1)) begin
              push_req_s  = 1'b1;
              cnt_nxt_s   = {CW{1'b0}};
              state_nxt_s = ST_IDLE;
            end else begin
              cnt_nxt_s = cnt_r + CW'(1);
            end
          end
        end else begin
`ifdef BUS_RX_TIMEOUT_EN
          if (tmo_r == TW'(TIMEOUT - 1)) begin
            err_s       = 1'b1;
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = ST_IDLE;
          end else begin
            tmo_nxt_s = tmo_r + TW'(1);
          end
`else
          state_nxt_s = ST_COLLECT;
`endif
        end
      end
      default: begin
        cnt_nxt_s   = {CW{1'b0}};
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO control: pointer updates, overflow detection and next head word.
  always_comb begin
    pop_s  = out_valid_r & out_ready;
    full_s = ((wptr_r - rptr_r) == (PW+1)'(FIFO_DEPTH));
    // A pop frees a slot in the same cycle, so full + push + pop succeeds.
    push_s = push_req_s & (~full_s | pop_s);
    ovf_s  = push_req_s & full_s & ~pop_s;
    if (push_s) begin
      wptr_nxt_s = wptr_r + (PW+1)'(1);
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (pop_s) begin
      rptr_nxt_s = rptr_r + (PW+1)'(1);
    end else begin
      rptr_nxt_s = rptr_r;
    end
    if (wptr_nxt_s != rptr_nxt_s) begin
      // When the next head is the slot being written this cycle, bypass the
      // storage so the word is visible one cycle after its last byte.
      if (push_s && (rptr_nxt_s == wptr_r)) begin
        head_nxt_s = {src_r, asm_nxt_s};
      end else begin
        head_nxt_s = mem_r[rptr_nxt_s[PW-1:0]];
      end
    end else begin
      head_nxt_s = {out_src_r, out_data_r};
    end
  end

  // FSM and assembly registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      src_r   <= 2'b00;
      asm_r   <= {W{1'b0}};
`ifdef BUS_RX_TIMEOUT_EN
      tmo_r   <= {TW{1'b0}};
`endif
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      src_r   <= src_nxt_s;
      asm_r   <= asm_nxt_s;
`ifdef BUS_RX_TIMEOUT_EN
      tmo_r   <= tmo_nxt_s;
`endif
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {(W+2){1'b0}};
      end
      wptr_r <= {(PW+1){1'b0}};
      rptr_r <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wptr_r[PW-1:0]] <= {src_r, asm_nxt_s};
      end
      wptr_r <= wptr_nxt_s;
      rptr_r <= rptr_nxt_s;
    end
  end

  // Registered outputs: head word, status and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_src_r   <= 2'b00;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      out_valid_r <= (wptr_nxt_s != rptr_nxt_s);
      out_data_r  <= head_nxt_s[W-1:0];
      out_src_r   <= head_nxt_s[W+1:W];
      busy_r      <= (cnt_nxt_s != {CW{1'b0}});
      frame_err_r <= err_s;
      overflow_r  <= ovf_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_bus_frame_receiver
//
// Purpose:
//   Self-checking bench for bus_frame_receiver. A queue-based reference model
//   (partial-frame byte list plus word FIFO queue) predicts every output after
//   every clock edge; directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_bus_frame_receiver;

  localparam int ADDRW   = 24;
  localparam int W       = ADDRW + 8;
  localparam int NB      = W / 8;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bus_valid;
  logic [7:0]   bus_data;
  logic [1:0]   bus_src;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         busy;
  logic         frame_err;
  logic         overflow;

  always #5 clk = ~clk;

  bus_frame_receiver #(
    .ADDRW      (ADDRW),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_src   (bus_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .busy      (busy),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0]   m_part[$];
  logic [1:0]   m_psrc;
  int           m_idle;
  logic [W+1:0] m_q[$];
  logic [W-1:0] m_last_data;
  logic [1:0]   m_last_src;
  logic         m_err;
  logic         m_ovf;

  function automatic void model_reset();
    m_part.delete();
    m_q.delete();
    m_psrc      = 2'b00;
    m_idle      = 0;
    m_last_data = '0;
    m_last_src  = 2'b00;
    m_err       = 1'b0;
    m_ovf       = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d,
                                     input logic [1:0] s, input logic r);
    bit           pop;
    bit           full;
    bit           done;
    logic [W-1:0] word;
    pop   = (m_q.size() != 0) && r;
    full  = (m_q.size() == DEPTH);
    done  = 1'b0;
    word  = '0;
    m_err = 1'b0;
    m_ovf = 1'b0;
    if (v) begin
      m_idle = 0;
      if (!(s == 2'b01 || s == 2'b10)) begin
        m_err = 1'b1;
        m_part.delete();
      end else begin
        if (m_part.size() != 0 && s != m_psrc) begin
          m_err = 1'b1;
          m_part.delete();
        end
        if (m_part.size() == 0) m_psrc = s;
        m_part.push_back(d);
        if (m_part.size() == NB) begin
          done = 1'b1;
          for (int i = 0; i < NB; i++) word = word + (W'(m_part[i]) << (8 * i));
          m_part.delete();
        end
      end
    end else begin
`ifdef BUS_RX_TIMEOUT_EN
      if (m_part.size() != 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_err = 1'b1;
          m_part.delete();
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
`endif
    end
    if (pop) void'(m_q.pop_front());
    if (done) begin
      if (full && !pop) m_ovf = 1'b1;
      else m_q.push_back({m_psrc, word});
    end
    if (m_q.size() != 0) begin
      m_last_data = m_q[0][W-1:0];
      m_last_src  = m_q[0][W+1:W];
    end
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".out_valid"}, out_valid, m_q.size() != 0);
    check_eq({tag, ".out_data"},  out_data,  m_last_data);
    check_eq({tag, ".out_src"},   out_src,   m_last_src);
    check_eq({tag, ".busy"},      busy,      m_part.size() != 0);
    check_eq({tag, ".frame_err"}, frame_err, m_err);
    check_eq({tag, ".overflow"},  overflow,  m_ovf);
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic [1:0] s, input logic r);
    bus_valid = v;
    bus_data  = d;
    bus_src   = s;
    out_ready = r;
    @(posedge clk);
    model_step(v, d, s, r);
    #1;
    check_outputs(tag);
  endtask

  task automatic send_frame(input string tag, input logic [W-1:0] word,
                            input logic [1:0] s, input logic r);
    for (int i = 0; i < NB; i++) step(tag, 1'b1, word[8*i +: 8], s, r);
  endtask

  task automatic do_reset(input string tag);
    bus_valid = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] cur_src;
    logic [1:0] s;
    logic       v;
    logic       r;

    rst_n     = 1'b0;
    bus_valid = 1'b0;
    bus_data  = 8'h00;
    bus_src   = 2'b00;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: single AES frame, consumer ready
    step("t1_b0", 1'b1, 8'hEF, 2'b01, 1'b1);
    check_eq("t1_busy_b1", busy, 1'b1);
    step("t1_b1", 1'b1, 8'hBE, 2'b01, 1'b1);
    step("t1_b2", 1'b1, 8'hAD, 2'b01, 1'b1);
    step("t1_b3", 1'b1, 8'hDE, 2'b01, 1'b1);
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_data", out_data, 32'hDEADBEEF);
    check_eq("t1_src", out_src, 2'b01);
    check_eq("t1_busy_end", busy, 1'b0);
    step("t1_idle", 1'b0, 8'h00, 2'b00, 1'b1);

    // T2: SHA then AES back-to-back, consumer stalled, then drain
    send_frame("t2_f1", 32'h11223344, 2'b10, 1'b0);
    send_frame("t2_f2", 32'h55667788, 2'b01, 1'b0);
    check_eq("t2_head", out_data, 32'h11223344);
    check_eq("t2_head_src", out_src, 2'b10);
    step("t2_pop1", 1'b0, 8'h00, 2'b00, 1'b1);
    check_eq("t2_second", out_data, 32'h55667788);
    check_eq("t2_second_src", out_src, 2'b01);
    step("t2_pop2", 1'b0, 8'h00, 2'b00, 1'b1);
    check_eq("t2_empty", out_valid, 1'b0);

    // T3: three frames into a depth-2 FIFO with the consumer stalled
    send_frame("t3_f1", 32'hA1A2A3A4, 2'b01, 1'b0);
    send_frame("t3_f2", 32'hB1B2B3B4, 2'b10, 1'b0);
    send_frame("t3_f3", 32'hC1C2C3C4, 2'b01, 1'b0);
    check_eq("t3_overflow", overflow, 1'b1);
    step("t3_hold", 1'b0, 8'h00, 2'b00, 1'b0);
    check_eq("t3_ovf_once", overflow, 1'b0);
    check_eq("t3_head_hold", out_data, 32'hA1A2A3A4);
    step("t3_pop1", 1'b0, 8'h00, 2'b00, 1'b1);
    check_eq("t3_second", out_data, 32'hB1B2B3B4);
    step("t3_pop2", 1'b0, 8'h00, 2'b00, 1'b1);
    step("t3_empty", 1'b0, 8'h00, 2'b00, 1'b1);

    // T4: source change mid-frame restarts under the new owner
    step("t4_a0", 1'b1, 8'h01, 2'b01, 1'b1);
    step("t4_a1", 1'b1, 8'h02, 2'b01, 1'b1);
    step("t4_s0", 1'b1, 8'hAA, 2'b10, 1'b1);
    check_eq("t4_err", frame_err, 1'b1);
    step("t4_s1", 1'b1, 8'hBB, 2'b10, 1'b1);
    step("t4_s2", 1'b1, 8'hCC, 2'b10, 1'b1);
    step("t4_s3", 1'b1, 8'hDD, 2'b10, 1'b1);
    check_eq("t4_data", out_data, 32'hDDCCBBAA);
    check_eq("t4_src", out_src, 2'b10);
    step("t4_illegal", 1'b1, 8'h55, 2'b11, 1'b0);

    // T5: reset with a queued word and a partial frame
    send_frame("t5_q", 32'h0BADF00D, 2'b01, 1'b0);
    step("t5_p0", 1'b1, 8'h10, 2'b10, 1'b0);
    step("t5_p1", 1'b1, 8'h20, 2'b10, 1'b0);
    do_reset("t5_rst");
    check_eq("t5_valid", out_valid, 1'b0);
    check_eq("t5_busy", busy, 1'b0);
    send_frame("t5_f", 32'hCAFEF00D, 2'b10, 1'b1);
    check_eq("t5_data", out_data, 32'hCAFEF00D);

    // T6: long gap inside a frame
    step("t6_b0", 1'b1, 8'h44, 2'b01, 1'b1);
    step("t6_b1", 1'b1, 8'h33, 2'b01, 1'b1);
    for (int i = 0; i < TIMEOUT + 3; i++) step("t6_gap", 1'b0, 8'h00, 2'b00, 1'b1);
    step("t6_b2", 1'b1, 8'h22, 2'b01, 1'b1);
    step("t6_b3", 1'b1, 8'h11, 2'b01, 1'b1);
    step("t6_idle", 1'b0, 8'h00, 2'b00, 1'b1);

    // Randomized traffic
    cur_src = 2'b01;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int g = 0; g < TIMEOUT + 2; g++) step("rnd_gap", 1'b0, 8'h00, 2'b00, 1'b1);
      end
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      s = cur_src;
      if ($urandom_range(0, 19) == 0) begin
        s = 2'($urandom_range(0, 3));
        if (s == 2'b01 || s == 2'b10) cur_src = s;
      end
      step("rnd", v, 8'($urandom), s, r);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
